kappa3_dbg_ctrl: RTL and testbench
==================================

KAPPA3_DBG_CTRL -- requirements
Module: kappa3_dbg_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles address/data are driven before the strobe.
REQ-002 Parameter STROBE_CYC, default 1: cycles a load/read/write strobe is held high.
REQ-003 Parameter SETTLE_CYC, default 2: cycles after the strobe before readback data is sampled.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high.
REQ-007 cmd_op  in  3  0 RD_PC, 1 WR_PC, 2 RD_REG, 3 WR_REG, 4 RD_MEM, 5 WR_MEM, 6 WR_IR, 7 RD_IR.
REQ-008 cmd_addr, cmd_data  in  32, 32  register index or memory address; write data.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-010 rsp_data, rsp_err  out  32, 1  readback value (0 for writes); error flag.
REQ-011 running  in  1  core run status from the core.
REQ-012 dbg_in, dbg_mem_addr  out  32, 32  core debug data and memory address.
REQ-013 dbg_reg_addr  out  5  core debug register index.
REQ-014 dbg_pc_ld, dbg_ir_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write  out  1 each  core debug strobes.
REQ-015 dbg_pc_out, dbg_ir_out, dbg_reg_out, dbg_mem_out  in  32 each  core readback buses.

Function
REQ-016 FSM states: IDLE, CHECK, SETUP, STROBE, SETTLE, RESP.
REQ-017 cmd_ready is high only in IDLE; on accept, the FSM latches op, addr and data and moves to CHECK.
REQ-018 In CHECK, any one of the following gives rsp_err=1 and a direct move to RESP with no strobe: running=1; a REG op with cmd_addr[31:5]!=0; a MEM op with cmd_addr[1:0]!=0.
REQ-019 Otherwise the FSM goes SETUP (SETUP_CYC cycles) -> STROBE (STROBE_CYC cycles) -> SETTLE (SETTLE_CYC cycles) -> RESP; each state has its own down-counter.
REQ-020 dbg_in, dbg_reg_addr and dbg_mem_addr are driven from the latched command from SETUP through SETTLE, and are held stable throughout.
REQ-021 Strobes are high only in STROBE: WR_PC->dbg_pc_ld, WR_IR->dbg_ir_ld, WR_REG->dbg_reg_ld, RD_MEM->dbg_mem_read, WR_MEM->dbg_mem_write.
REQ-022 RD_PC, RD_REG and RD_IR assert no strobe; they only drive the address and wait out the timing.
REQ-023 At most one strobe is high in any cycle.
REQ-024 On the last SETTLE cycle, the FSM registers rsp_data from the bus selected by op; writes give 0.
REQ-025 In RESP, rsp_valid=1, and rsp_data/rsp_err hold until rsp_ready=1; the FSM then returns to IDLE.
REQ-026 Back-to-back operation: when rsp_ready is already high, a new command can be accepted in the cycle after the response transfer.
REQ-027 If running rises mid-sequence, the sequence completes unchanged; the check is made only in CHECK.
REQ-028 Write latency with default parameters: 1 accept + 1 check + 1 setup + 1 strobe + 2 settle = rsp_valid in cycle 6 after the accept edge.

Reset
REQ-029 Reset low forces, immediately and regardless of clock: state=IDLE, all strobes=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, dbg_in=0, dbg_mem_addr=0, dbg_reg_addr=0, counters=0.
REQ-030 Reset during a sequence aborts it with no response.
REQ-031 cmd_ready rises in the first cycle after reset deasserts.

Structure
REQ-032 Package kappa3_dbg_pkg holds the op encoding enum, the FSM state enum and the default timing constants.
REQ-033 No sub-module; the FSM, counters and output mux are in one module.

Verification
REQ-034 WR_PC 0x00000100, then RD_PC -> dbg_pc_ld high for exactly 1 cycle; rsp_data=0x00000100, rsp_err=0.
REQ-035 WR_REG x5=0xDEADBEEF, then RD_REG 5 -> dbg_reg_addr=5 during the sequence; rsp_data=0xDEADBEEF.
REQ-036 WR_MEM 0x40=0x12345678, then RD_MEM 0x40 -> one dbg_mem_write pulse and one dbg_mem_read pulse; rsp_data=0x12345678.
REQ-037 Error cases: RD_MEM 0x42 -> rsp_err=1, no strobe; RD_REG 32 -> rsp_err=1; any op with running=1 -> rsp_err=1, no strobe.
REQ-038 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable; cmd_ready stays 0.
REQ-039 Pull reset low during STROBE -> strobe drops with no clock edge; no response; cmd_ready returns after reset is released.

Source files
------------

// File: rtl/kappa3_dbg_pkg.sv
// Shared encodings and default timing for the kappa3 debug controller.
package kappa3_dbg_pkg;

  typedef enum logic [2:0] {
    OP_RD_PC  = 3'd0,
    OP_WR_PC  = 3'd1,
    OP_RD_REG = 3'd2,
    OP_WR_REG = 3'd3,
    OP_RD_MEM = 3'd4,
    OP_WR_MEM = 3'd5,
    OP_WR_IR  = 3'd6,
    OP_RD_IR  = 3'd7
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RESP   = 3'd5
  } dbg_state_e;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 1;
  localparam int DEF_SETTLE_CYC = 2;

  // Width of the per-phase down-counters; phase lengths must be 1..256.
  localparam int CNT_W = 8;

  function automatic logic is_reg_op(input dbg_op_e op);
    return (op == OP_RD_REG) || (op == OP_WR_REG);
  endfunction

  function automatic logic is_mem_op(input dbg_op_e op);
    return (op == OP_RD_MEM) || (op == OP_WR_MEM);
  endfunction

endpackage

// File: rtl/kappa3_dbg_ctrl.sv
// Debug-port sequencer for the kappa3 core: accepts one command, times the
// address setup / strobe / settle phases against the core, returns one response.
// Note: the port named 'reset' is active-low.
module kappa3_dbg_ctrl
  import kappa3_dbg_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        running,
  output logic [31:0] dbg_in,
  output logic [31:0] dbg_mem_addr,
  output logic [4:0]  dbg_reg_addr,
  output logic        dbg_pc_ld,
  output logic        dbg_ir_ld,
  output logic        dbg_reg_ld,
  output logic        dbg_mem_read,
  output logic        dbg_mem_write,
  input  logic [31:0] dbg_pc_out,
  input  logic [31:0] dbg_ir_out,
  input  logic [31:0] dbg_reg_out,
  input  logic [31:0] dbg_mem_out
);

  // Counters are loaded with length-1 and the phase ends when they reach zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  dbg_state_e       r_state;
  dbg_state_e       w_next_state;
  dbg_op_e          r_op;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;
  logic             r_armed;
  logic [CNT_W-1:0] r_setup_cnt;
  logic [CNT_W-1:0] r_strobe_cnt;
  logic [CNT_W-1:0] r_settle_cnt;
  logic             w_accept;
  logic             w_check_err;
  logic             w_drive;
  logic [31:0]      w_read_data;

  // r_armed keeps cmd_ready low until the first clock after reset release.
  assign w_accept    = cmd_valid && r_armed && (r_state == ST_IDLE);
  assign w_check_err = running
                    || (is_reg_op(r_op) && (r_addr[31:5] != '0))
                    || (is_mem_op(r_op) && (r_addr[1:0] != 2'b00));
  assign w_drive     = (r_state == ST_SETUP) || (r_state == ST_STROBE)
                    || (r_state == ST_SETTLE);

  assign dbg_in       = w_drive ? r_data      : '0;
  assign dbg_mem_addr = w_drive ? r_addr      : '0;
  assign dbg_reg_addr = w_drive ? r_addr[4:0] : '0;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;

  // Select the core readback bus for the latched op; writes read back zero.
  always_comb begin
    w_read_data = '0;
    case (r_op)
      OP_RD_PC:  w_read_data = dbg_pc_out;
      OP_RD_REG: w_read_data = dbg_reg_out;
      OP_RD_MEM: w_read_data = dbg_mem_out;
      OP_RD_IR:  w_read_data = dbg_ir_out;
      default:   w_read_data = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus handshake and strobe outputs decoded from state.
  always_comb begin
    w_next_state  = r_state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    dbg_pc_ld     = 1'b0;
    dbg_ir_ld     = 1'b0;
    dbg_reg_ld    = 1'b0;
    dbg_mem_read  = 1'b0;
    dbg_mem_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = r_armed;
        if (w_accept) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        w_next_state = w_check_err ? ST_RESP : ST_SETUP;
      end
      ST_SETUP: begin
        if (r_setup_cnt == '0) w_next_state = ST_STROBE;
      end
      ST_STROBE: begin
        dbg_pc_ld     = (r_op == OP_WR_PC);
        dbg_ir_ld     = (r_op == OP_WR_IR);
        dbg_reg_ld    = (r_op == OP_WR_REG);
        dbg_mem_read  = (r_op == OP_RD_MEM);
        dbg_mem_write = (r_op == OP_WR_MEM);
        if (r_strobe_cnt == '0) w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == '0) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Command latch, phase counters and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_armed      <= 1'b0;
      r_op         <= OP_RD_PC;
      r_addr       <= '0;
      r_data       <= '0;
      r_setup_cnt  <= '0;
      r_strobe_cnt <= '0;
      r_settle_cnt <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= dbg_op_e'(cmd_op);
            r_addr <= cmd_addr;
            r_data <= cmd_data;
          end
        end
        ST_CHECK: begin
          r_rsp_data  <= '0;
          r_rsp_err   <= w_check_err;
          r_setup_cnt <= SETUP_LOAD;
        end
        ST_SETUP: begin
          if (r_setup_cnt == '0) r_strobe_cnt <= STROBE_LOAD;
          else                   r_setup_cnt  <= r_setup_cnt - CNT_ONE;
        end
        ST_STROBE: begin
          if (r_strobe_cnt == '0) r_settle_cnt <= SETTLE_LOAD;
          else                    r_strobe_cnt <= r_strobe_cnt - CNT_ONE;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) r_rsp_data   <= w_read_data;
          else                    r_settle_cnt <= r_settle_cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kappa3_dbg_ctrl.sv
// Self-checking bench for kappa3_dbg_ctrl: a small core model answers the
// debug strobes, and a command-level reference model predicts every response.
module tb_kappa3_dbg_ctrl;

  localparam int SETUP  = 1;
  localparam int STROBE = 1;
  localparam int SETTLE = 2;

  localparam logic [2:0] OP_RD_PC  = 3'd0;
  localparam logic [2:0] OP_WR_PC  = 3'd1;
  localparam logic [2:0] OP_RD_REG = 3'd2;
  localparam logic [2:0] OP_WR_REG = 3'd3;
  localparam logic [2:0] OP_RD_MEM = 3'd4;
  localparam logic [2:0] OP_WR_MEM = 3'd5;
  localparam logic [2:0] OP_WR_IR  = 3'd6;
  localparam logic [2:0] OP_RD_IR  = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, running;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_data, rsp_data, dbg_in, dbg_mem_addr;
  logic [4:0]  dbg_reg_addr;
  logic        dbg_pc_ld, dbg_ir_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write;
  logic [31:0] dbg_pc_out, dbg_ir_out, dbg_reg_out, dbg_mem_out;

  int n_cmp  = 0;
  int n_fail = 0;

  kappa3_dbg_ctrl #(.SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .SETTLE_CYC(SETTLE)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .running(running), .dbg_in(dbg_in), .dbg_mem_addr(dbg_mem_addr),
    .dbg_reg_addr(dbg_reg_addr), .dbg_pc_ld(dbg_pc_ld), .dbg_ir_ld(dbg_ir_ld),
    .dbg_reg_ld(dbg_reg_ld), .dbg_mem_read(dbg_mem_read), .dbg_mem_write(dbg_mem_write),
    .dbg_pc_out(dbg_pc_out), .dbg_ir_out(dbg_ir_out), .dbg_reg_out(dbg_reg_out),
    .dbg_mem_out(dbg_mem_out)
  );

  always #5 clock = ~clock;

  // Core model: registers load on the strobe edge, readback is combinational.
  logic [31:0] sim_pc = '0;
  logic [31:0] sim_ir = '0;
  logic [31:0] sim_regs [32]  = '{default: '0};
  logic [31:0] sim_mem  [256] = '{default: '0};
  assign dbg_pc_out  = sim_pc;
  assign dbg_ir_out  = sim_ir;
  assign dbg_reg_out = sim_regs[dbg_reg_addr];
  assign dbg_mem_out = sim_mem[dbg_mem_addr[9:2]];

  always @(posedge clock) begin
    if (dbg_pc_ld)     sim_pc <= dbg_in;
    if (dbg_ir_ld)     sim_ir <= dbg_in;
    if (dbg_reg_ld)    sim_regs[dbg_reg_addr] <= dbg_in;
    if (dbg_mem_write) sim_mem[dbg_mem_addr[9:2]] <= dbg_in;
  end

  // Reference state of the core as seen at the command level.
  logic [31:0] ref_pc = '0;
  logic [31:0] ref_ir = '0;
  logic [31:0] ref_regs [32]  = '{default: '0};
  logic [31:0] ref_mem  [256] = '{default: '0};

  // Bus monitor: strobe totals, multi-strobe cycles, address/data changes mid-sequence.
  int tot_pc = 0, tot_ir = 0, tot_reg = 0, tot_mrd = 0, tot_mwr = 0;
  int multi_cnt = 0, chg_cnt = 0;
  bit in_seq = 1'b0;
  logic [68:0] prev_bus = '0;
  logic [68:0] cur_bus;
  always @(negedge clock) begin
    cur_bus = {dbg_in, dbg_mem_addr, dbg_reg_addr};
    if ((int'(dbg_pc_ld) + int'(dbg_ir_ld) + int'(dbg_reg_ld) + int'(dbg_mem_read)
         + int'(dbg_mem_write)) > 1) multi_cnt++;
    if (in_seq) begin
      tot_pc  += int'(dbg_pc_ld);
      tot_ir  += int'(dbg_ir_ld);
      tot_reg += int'(dbg_reg_ld);
      tot_mrd += int'(dbg_mem_read);
      tot_mwr += int'(dbg_mem_write);
      if (cur_bus != '0 && prev_bus != '0 && cur_bus != prev_bus) chg_cnt++;
    end
    prev_bus = cur_bus;
  end

  logic [31:0] snap_in, snap_maddr;
  logic [4:0]  snap_raddr;

  // Reference model: response, edges to rsp_valid and strobe counts {pc,ir,reg,mrd,mwr}.
  task automatic model_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input bit run, output logic [31:0] ed, output logic ee,
                           output int el, output logic [19:0] es);
    bit is_reg, is_mem;
    is_reg = (op == OP_RD_REG) || (op == OP_WR_REG);
    is_mem = (op == OP_RD_MEM) || (op == OP_WR_MEM);
    ee = run || (is_reg && addr > 32'd31) || (is_mem && (addr % 4) != 0);
    el = ee ? 1 : 1 + SETUP + STROBE + SETTLE;
    ed = '0;
    es = '0;
    if (!ee) begin
      case (op)
        OP_RD_PC:  ed = ref_pc;
        OP_WR_PC:  begin ref_pc = data; es = 20'(STROBE) << 16; end
        OP_RD_REG: ed = ref_regs[addr[4:0]];
        OP_WR_REG: begin ref_regs[addr[4:0]] = data; es = 20'(STROBE) << 8; end
        OP_RD_MEM: begin ed = ref_mem[addr[9:2]]; es = 20'(STROBE) << 4; end
        OP_WR_MEM: begin ref_mem[addr[9:2]] = data; es = 20'(STROBE); end
        OP_WR_IR:  begin ref_ir = data; es = 20'(STROBE) << 12; end
        default:   ed = ref_ir;
      endcase
    end
  endtask

  // Drives one command through the handshakes and reports what came back.
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input int rdy_delay, input bit run_val, input bit raise_run,
                        output logic [31:0] got_data, output logic got_err, output int lat,
                        output logic [19:0] got_stb, output int unstable, output bit timed_out);
    int n;
    int b_pc, b_ir, b_reg, b_mrd, b_mwr;
    timed_out = 1'b0; got_data = '0; got_err = 1'b0; lat = 0; got_stb = '0; unstable = 0;
    running = run_val; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    if (cmd_ready !== 1'b1) begin cmd_valid = 1'b0; running = 1'b0; timed_out = 1'b1; return; end
    b_pc = tot_pc; b_ir = tot_ir; b_reg = tot_reg; b_mrd = tot_mrd; b_mwr = tot_mwr;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    in_seq = 1'b1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (raise_run && lat == 1) running = 1'b1;
      if (lat == 2) begin snap_in = dbg_in; snap_maddr = dbg_mem_addr; snap_raddr = dbg_reg_addr; end
    end
    if (rsp_valid !== 1'b1) begin in_seq = 1'b0; running = 1'b0; timed_out = 1'b1; return; end
    got_data = rsp_data;
    got_err  = rsp_err;
    repeat (rdy_delay) begin
      @(posedge clock); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== got_data || rsp_err !== got_err || cmd_ready !== 1'b0)
        unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    in_seq = 1'b0;
    running = 1'b0;
    got_stb = {4'(tot_pc - b_pc), 4'(tot_ir - b_ir), 4'(tot_reg - b_reg),
               4'(tot_mrd - b_mrd), 4'(tot_mwr - b_mwr)};
  endtask

  logic [31:0] g_data, e_data;
  logic        g_err, e_err;
  int          g_lat, e_lat, g_unst;
  logic [19:0] g_stb, e_stb;
  bit          g_to;

  task automatic test_reset();
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp: got %h/%b want 0/0", rsp_data, rsp_err); end
    n_cmp++; if ({dbg_in, dbg_mem_addr, dbg_reg_addr} !== '0) begin n_fail++; $display("[TB] FAIL reset_dbg_bus: got %h %h %h want 0", dbg_in, dbg_mem_addr, dbg_reg_addr); end
    n_cmp++; if ({dbg_pc_ld, dbg_ir_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b want 0", {dbg_pc_ld, dbg_ir_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write}); end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_held_cmd_ready: got %b want 0", cmd_ready); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_pc();
    model_cmd(OP_WR_PC, 32'h0, 32'h0000_0100, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_WR_PC, 32'h0, 32'h0000_0100, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_to !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_pc_timeout: got %b want 0", g_to); end
    n_cmp++; if (g_stb !== 20'h10000) begin n_fail++; $display("[TB] FAIL wr_pc_strobe: got %h want 10000", g_stb); end
    n_cmp++; if (g_lat !== 5) begin n_fail++; $display("[TB] FAIL wr_pc_latency: got %0d want 5", g_lat); end
    n_cmp++; if (g_data !== 32'h0 || g_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_pc_rsp: got %h/%b want 0/0", g_data, g_err); end
    model_cmd(OP_RD_PC, 32'h0, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_PC, 32'h0, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_data !== 32'h0000_0100 || g_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_pc_rsp: got %h/%b want 00000100/0", g_data, g_err); end
    n_cmp++; if (g_stb !== 20'h0) begin n_fail++; $display("[TB] FAIL rd_pc_strobe: got %h want 0", g_stb); end
  endtask

  task automatic test_reg();
    model_cmd(OP_WR_REG, 32'd5, 32'hDEAD_BEEF, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_WR_REG, 32'd5, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_stb !== e_stb) begin n_fail++; $display("[TB] FAIL wr_reg_strobe: got %h want %h", g_stb, e_stb); end
    n_cmp++; if (snap_in !== 32'hDEAD_BEEF || snap_raddr !== 5'd5) begin n_fail++; $display("[TB] FAIL wr_reg_bus: got %h/%0d want deadbeef/5", snap_in, snap_raddr); end
    model_cmd(OP_RD_REG, 32'd5, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_REG, 32'd5, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (snap_raddr !== 5'd5) begin n_fail++; $display("[TB] FAIL rd_reg_addr: got %0d want 5", snap_raddr); end
    n_cmp++; if (g_data !== 32'hDEAD_BEEF || g_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_reg_rsp: got %h/%b want deadbeef/0", g_data, g_err); end
  endtask

  task automatic test_mem();
    model_cmd(OP_WR_MEM, 32'h40, 32'h1234_5678, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_WR_MEM, 32'h40, 32'h1234_5678, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_stb !== 20'h00001) begin n_fail++; $display("[TB] FAIL wr_mem_strobe: got %h want 00001", g_stb); end
    n_cmp++; if (snap_maddr !== 32'h40) begin n_fail++; $display("[TB] FAIL wr_mem_addr: got %h want 40", snap_maddr); end
    model_cmd(OP_RD_MEM, 32'h40, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_MEM, 32'h40, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_stb !== 20'h00010) begin n_fail++; $display("[TB] FAIL rd_mem_strobe: got %h want 00010", g_stb); end
    n_cmp++; if (g_data !== 32'h1234_5678 || g_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_mem_rsp: got %h/%b want 12345678/0", g_data, g_err); end
  endtask

  task automatic test_errors();
    model_cmd(OP_RD_MEM, 32'h42, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_MEM, 32'h42, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_err !== 1'b1 || g_stb !== 20'h0) begin n_fail++; $display("[TB] FAIL err_misaligned: got err %b stb %h want 1/0", g_err, g_stb); end
    n_cmp++; if (g_lat !== 1) begin n_fail++; $display("[TB] FAIL err_latency: got %0d want 1", g_lat); end
    model_cmd(OP_RD_REG, 32'd32, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_REG, 32'd32, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_err !== 1'b1 || g_data !== 32'h0) begin n_fail++; $display("[TB] FAIL err_reg_index: got %h/%b want 0/1", g_data, g_err); end
    model_cmd(OP_WR_PC, 32'h0, 32'hCAFE_0000, 1'b1, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_WR_PC, 32'h0, 32'hCAFE_0000, 0, 1'b1, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_err !== 1'b1 || g_stb !== 20'h0) begin n_fail++; $display("[TB] FAIL err_running: got err %b stb %h want 1/0", g_err, g_stb); end
    model_cmd(OP_RD_PC, 32'h0, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_PC, 32'h0, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_data !== e_data) begin n_fail++; $display("[TB] FAIL err_pc_untouched: got %h want %h", g_data, e_data); end
  endtask

  task automatic test_running_mid();
    model_cmd(OP_WR_IR, 32'h0, 32'h0BAD_F00D, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_WR_IR, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b1, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_err !== 1'b0 || g_stb !== 20'h01000) begin n_fail++; $display("[TB] FAIL run_mid_wr_ir: got err %b stb %h want 0/01000", g_err, g_stb); end
    model_cmd(OP_RD_IR, 32'h0, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_IR, 32'h0, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_data !== 32'h0BAD_F00D) begin n_fail++; $display("[TB] FAIL run_mid_rd_ir: got %h want 0badf00d", g_data); end
  endtask

  task automatic test_hold_ready();
    model_cmd(OP_RD_REG, 32'd5, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_REG, 32'd5, 32'h0, 5, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_unst !== 0) begin n_fail++; $display("[TB] FAIL hold_stable: got %0d unstable cycles want 0", g_unst); end
    n_cmp++; if (g_data !== e_data) begin n_fail++; $display("[TB] FAIL hold_data: got %h want %h", g_data, e_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n;
    v = $urandom;
    model_cmd(OP_WR_REG, 32'd7, v, 1'b0, e_data, e_err, e_lat, e_stb);
    model_cmd(OP_RD_REG, 32'd7, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    rsp_ready = 1'b1; running = 1'b0;
    cmd_op = OP_WR_REG; cmd_addr = 32'd7; cmd_data = v; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    cmd_op = OP_RD_REG; cmd_data = 32'h0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_rsp: got %b want 1", rsp_valid); end
    @(posedge clock); #1;
    n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle: got rdy %b vld %b want 1/0", cmd_ready, rsp_valid); end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept: got rdy %b want 0", cmd_ready); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    n_cmp++; if (rsp_data !== e_data || rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_rsp: got %h/%b want %h/0", rsp_data, rsp_err, e_data); end
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] addr, data;
    int kind, dly;
    bit run;
    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      data = $urandom;
      dly  = $urandom_range(0, 3);
      run  = ($urandom_range(0, 9) == 0);
      if (op == OP_RD_REG || op == OP_WR_REG)
        addr = (kind < 8) ? 32'($urandom_range(0, 31)) : 32'(32 + $urandom_range(0, 1000));
      else if (op == OP_RD_MEM || op == OP_WR_MEM)
        addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00} | ((kind < 8) ? 32'd0 : 32'($urandom_range(1, 3)));
      else
        addr = $urandom;
      model_cmd(op, addr, data, run, e_data, e_err, e_lat, e_stb);
      do_cmd(op, addr, data, dly, run, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
      n_cmp++; if (g_to !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_timeout: op %0d", i, op); end
      n_cmp++; if (g_err !== e_err || g_data !== e_data) begin n_fail++; $display("[TB] FAIL rnd%0d_rsp: op %0d addr %h got %h/%b want %h/%b", i, op, addr, g_data, g_err, e_data, e_err); end
      n_cmp++; if (g_lat !== e_lat) begin n_fail++; $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", i, g_lat, e_lat); end
      n_cmp++; if (g_stb !== e_stb) begin n_fail++; $display("[TB] FAIL rnd%0d_strobes: op %0d got %h want %h", i, op, g_stb, e_stb); end
      n_cmp++; if (g_unst !== 0) begin n_fail++; $display("[TB] FAIL rnd%0d_hold: got %0d unstable want 0", i, g_unst); end
    end
  endtask

  task automatic test_reset_mid_strobe();
    int n, seen;
    rsp_ready = 1'b0; running = 1'b0;
    cmd_op = OP_WR_PC; cmd_addr = 32'h0; cmd_data = 32'hABCD_0000; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_cmp++; if (dbg_pc_ld !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_strobe_on: got %b want 1", dbg_pc_ld); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dbg_pc_ld !== 1'b0 || dbg_in !== 32'h0) begin n_fail++; $display("[TB] FAIL rstmid_async_drop: got ld %b in %h want 0/0", dbg_pc_ld, dbg_in); end
    n_cmp++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_handshake: got rdy %b vld %b want 0/0", cmd_ready, rsp_valid); end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready_back: got %b want 1", cmd_ready); end
    seen = 0;
    repeat (8) begin @(posedge clock); #1; if (rsp_valid !== 1'b0) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL rstmid_no_response: got %0d valid cycles want 0", seen); end
    model_cmd(OP_RD_PC, 32'h0, 32'h0, 1'b0, e_data, e_err, e_lat, e_stb);
    do_cmd(OP_RD_PC, 32'h0, 32'h0, 0, 1'b0, 1'b0, g_data, g_err, g_lat, g_stb, g_unst, g_to);
    n_cmp++; if (g_data !== e_data) begin n_fail++; $display("[TB] FAIL rstmid_pc_kept: got %h want %h", g_data, e_data); end
  endtask

  task automatic test_bus_hygiene();
    n_cmp++; if (multi_cnt !== 0) begin n_fail++; $display("[TB] FAIL one_strobe: got %0d multi-strobe cycles want 0", multi_cnt); end
    n_cmp++; if (chg_cnt !== 0) begin n_fail++; $display("[TB] FAIL bus_stable: got %0d bus changes want 0", chg_cnt); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; running = 1'b0;
    test_reset();
    test_pc();
    test_reg();
    test_mem();
    test_errors();
    test_running_mid();
    test_hold_ready();
    test_back_to_back();
    test_random();
    test_reset_mid_strobe();
    test_bus_hygiene();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
